// File: rtl/key_pkg.sv
// Shared key-event definitions: key indices, scan-code map and encoder FSM states.
package key_pkg;

  localparam int KEY_N = 14;

  localparam int K_W     = 13;
  localparam int K_A     = 12;
  localparam int K_S     = 11;
  localparam int K_D     = 10;
  localparam int K_T     = 9;
  localparam int K_Y     = 8;
  localparam int K_U     = 7;
  localparam int K_UP    = 6;
  localparam int K_DOWN  = 5;
  localparam int K_LEFT  = 4;
  localparam int K_RIGHT = 3;
  localparam int K_COMMA = 2;
  localparam int K_DOT   = 1;
  localparam int K_SLASH = 0;

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} key_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       press;
    logic [3:0] idx;
  } key_event_t;

  function automatic logic [7:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd13:   return 8'h1D;
      4'd12:   return 8'h1C;
      4'd11:   return 8'h1B;
      4'd10:   return 8'h23;
      4'd9:    return 8'h2C;
      4'd8:    return 8'h35;
      4'd7:    return 8'h3C;
      4'd6:    return 8'h75;
      4'd5:    return 8'h72;
      4'd4:    return 8'h6B;
      4'd3:    return 8'h74;
      4'd2:    return 8'h41;
      4'd1:    return 8'h49;
      4'd0:    return 8'h4A;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_arbiter.sv
// Find-first over the changed-key vector, searching upward from ptr and wrapping.
module key_arbiter
  import key_pkg::*;
(
  input  logic [KEY_N-1:0] diff,
  input  logic [3:0]       ptr,
  output logic [3:0]       idx,
  output logic             found
);

  // With ptr tied to 0 this collapses to plain lowest-index priority.
  always_comb begin
    int j;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < KEY_N; k++) begin
      j = (int'(ptr) + k) % KEY_N;
      if (!found && diff[j]) begin
        idx   = j[3:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// Serialises key-state changes into (keyCode, press) events over valid/ready.
// Define KEY_EVENT_RR_EN for round-robin arbitration instead of fixed priority.
module key_event_encoder
  import key_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int GAP_W      = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [KEY_N-1:0] keys,
  output logic [7:0]       keyCode,
  output logic             press,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic             busy
);

  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  key_state_t       state, next;
  key_event_t       ev;
  logic [KEY_N-1:0] sent, diff;
  logic [GAP_W-1:0] gap_cnt;
  logic [3:0]       ptr, idx;
  logic             found, accept;

  assign diff   = keys ^ sent;
  assign accept = (state == PRESENT) && ev_ready;

  key_arbiter u_arb (
    .diff  (diff),
    .ptr   (ptr),
    .idx   (idx),
    .found (found)
  );

`ifdef KEY_EVENT_RR_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)    ptr <= '0;
    else if (accept) ptr <= (ev.idx == 4'(KEY_N - 1)) ? 4'd0 : ev.idx + 4'd1;
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (found) next = PRESENT;
      PRESENT: if (ev_ready) next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == '0) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    ev_valid = (state == PRESENT);
    busy     = (state != IDLE) || (|diff);
  end

  // Event fields are captured once in IDLE and frozen until the handshake completes.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ev      <= '0;
      sent    <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == IDLE && found) begin
        ev.code  <= key_code(idx);
        ev.press <= keys[idx];
        ev.idx   <= idx;
      end
      if (accept) begin
        sent[ev.idx] <= ev.press;
        gap_cnt      <= GAP_LOAD;
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  assign keyCode = ev.code;
  assign press   = ev.press;

endmodule
